// File: rtl/bus_dma_master_if.sv
// Bus-side signals between the DMA master and the arbiter/memory: request, grant,
// address, and the read and write data paths.
interface bus_dma_master_if;
  logic        M_req;
  logic        M_wr;
  logic [7:0]  M_address;
  logic [31:0] M_dout;
  logic        M_grant;
  logic [31:0] M_din;

  modport master (
    output M_req, M_wr, M_address, M_dout,
    input  M_grant, M_din
  );

  modport slave (
    input  M_req, M_wr, M_address, M_dout,
    output M_grant, M_din
  );
endinterface

// File: rtl/bus_dma_master.sv
// Word-copy DMA master: read src+i, write dst+i, three cycles per word while granted.
// All outputs are registered; losing the grant parks in REQ and replays the current word.
module bus_dma_master (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       src_addr,
  input  logic [7:0]       dst_addr,
  input  logic [4:0]       length,
  bus_dma_master_if.master bus,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {IDLE, REQ, RD_ADDR, RD_DATA, WR, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  src_q, dst_q;
  logic [4:0]  len_q, idx_q, idx_nxt, idx_inc, len_eff;
  logic [31:0] buf_q, buf_nxt;
  logic        req_q, wr_q, busy_q, done_q;
  logic        req_nxt, wr_nxt, busy_nxt, done_nxt;
  logic [7:0]  addr_q, addr_nxt;
  logic [31:0] dout_q, dout_nxt;

  assign len_eff = (length > 5'd16) ? 5'd16 : length;
  assign idx_inc = idx_q + 5'd1;

  assign bus.M_req     = req_q;
  assign bus.M_wr      = wr_q;
  assign bus.M_address = addr_q;
  assign bus.M_dout    = dout_q;
  assign busy          = busy_q;
  assign done          = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      src_q  <= 8'h00;
      dst_q  <= 8'h00;
      len_q  <= 5'd0;
      idx_q  <= 5'd0;
      buf_q  <= 32'h0;
      req_q  <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= 8'h00;
      dout_q <= 32'h0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx_q  <= idx_nxt;
      buf_q  <= buf_nxt;
      req_q  <= req_nxt;
      wr_q   <= wr_nxt;
      addr_q <= addr_nxt;
      dout_q <= dout_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      if (state == IDLE && start) begin
        src_q <= src_addr;
        dst_q <= dst_addr;
        len_q <= len_eff;
      end
    end
  end

  // Any grant drop while on the bus falls back to REQ without advancing the word index.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (len_eff == 5'd0) ? DONE : REQ;
          idx_nxt   = 5'd0;
        end
      end
      REQ:     if (bus.M_grant) state_nxt = RD_ADDR;
      RD_ADDR: state_nxt = bus.M_grant ? RD_DATA : REQ;
      RD_DATA: state_nxt = bus.M_grant ? WR : REQ;
      WR: begin
        if (bus.M_grant) begin
          idx_nxt   = idx_inc;
          state_nxt = (idx_inc == len_q) ? DONE : RD_ADDR;
        end else begin
          state_nxt = REQ;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the state being entered.
  always_comb begin
    buf_nxt  = (state == RD_DATA) ? bus.M_din : buf_q;
    req_nxt  = (state_nxt == REQ) || (state_nxt == RD_ADDR) ||
               (state_nxt == RD_DATA) || (state_nxt == WR);
    wr_nxt   = (state_nxt == WR);
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
    addr_nxt = addr_q;
    dout_nxt = dout_q;
    case (state_nxt)
      RD_ADDR: addr_nxt = src_q + {3'b000, idx_nxt};
      WR: begin
        addr_nxt = dst_q + {3'b000, idx_nxt};
        dout_nxt = buf_nxt;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_dma_master.sv
// Directed bench for bus_dma_master: a combinational memory answers reads, and writes
// are logged only when issued while the grant is held.
module tb_bus_dma_master;
  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] src_addr;
  logic [7:0] dst_addr;
  logic [4:0] length;
  logic       busy;
  logic       done;

  bus_dma_master_if bus ();

  bus_dma_master dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .bus      (bus),
    .busy     (busy),
    .done     (done)
  );

  logic [31:0] mem [256];
  assign bus.M_din = mem[bus.M_address];

  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt = 0;
  int          req_cnt  = 0;
  logic [7:0]  log_addr [$];
  logic [31:0] log_dat  [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (!reset) begin
      if (bus.M_wr && bus.M_grant) begin
        log_addr.push_back(bus.M_address);
        log_dat.push_back(bus.M_dout);
      end
      if (done) done_cnt++;
      if (bus.M_req) req_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    done_cnt = 0;
    req_cnt  = 0;
    log_addr.delete();
    log_dat.delete();
  endtask

  task automatic issue(input logic [7:0] s, input logic [7:0] d, input logic [4:0] n);
    src_addr = s;
    dst_addr = d;
    length   = n;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic run_to_done(input string tag, input int bound);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < bound && !seen; c++) begin
      tick();
      seen = done;
    end
    chk({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
    tick();
  endtask

  task automatic chk_log(input string tag, input int k, input logic [7:0] a, input logic [31:0] d);
    if (log_addr.size() > k) begin
      chk({tag, "_addr"}, {24'b0, log_addr[k]}, {24'b0, a});
      chk({tag, "_data"}, log_dat[k], d);
    end else begin
      chk({tag, "_present"}, log_addr.size(), k + 1);
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'hEE00_0000 | k;
    reset = 1'b1;
    start = 1'b0;
    src_addr = 8'h00;
    dst_addr = 8'h00;
    length = 5'd0;
    bus.M_grant = 1'b1;
    tick();
    tick();
    chk("rst_req",  {31'b0, bus.M_req}, 32'd0);
    chk("rst_wr",   {31'b0, bus.M_wr}, 32'd0);
    chk("rst_addr", {24'b0, bus.M_address}, 32'h00);
    chk("rst_dout", bus.M_dout, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    // start is a don't-care while reset is held
    start = 1'b1;
    tick();
    chk("rst_prio_busy", {31'b0, busy}, 32'd0);
    start = 1'b0;
    reset = 1'b0;
    tick();

    // Granted two-word copy, checked cycle by cycle
    mem[8'h01] = 32'h0000_000A;
    mem[8'h02] = 32'h0000_000B;
    clear_log();
    issue(8'h01, 8'h10, 5'd2);
    chk("g_req_busy", {31'b0, busy}, 32'd1);
    chk("g_req_mreq", {31'b0, bus.M_req}, 32'd1);
    tick();
    chk("g_rd0_addr", {24'b0, bus.M_address}, 32'h01);
    chk("g_rd0_wr",   {31'b0, bus.M_wr}, 32'd0);
    tick();
    chk("g_rdd0_addr", {24'b0, bus.M_address}, 32'h01);
    tick();
    chk("g_wr0_wr",   {31'b0, bus.M_wr}, 32'd1);
    chk("g_wr0_addr", {24'b0, bus.M_address}, 32'h10);
    chk("g_wr0_dout", bus.M_dout, 32'h0000_000A);
    tick();
    chk("g_rd1_wr",   {31'b0, bus.M_wr}, 32'd0);
    chk("g_rd1_addr", {24'b0, bus.M_address}, 32'h02);
    tick();
    tick();
    chk("g_wr1_addr", {24'b0, bus.M_address}, 32'h11);
    chk("g_wr1_dout", bus.M_dout, 32'h0000_000B);
    tick();
    chk("g_done",      {31'b0, done}, 32'd1);
    chk("g_done_busy", {31'b0, busy}, 32'd1);
    chk("g_done_req",  {31'b0, bus.M_req}, 32'd0);
    tick();
    chk("g_idle_busy", {31'b0, busy}, 32'd0);
    chk("g_idle_done", {31'b0, done}, 32'd0);
    chk("g_nwrites",   log_addr.size(), 32'd2);
    chk("g_ndone",     done_cnt, 32'd1);

    // Delayed grant: request held, address frozen until the grant arrives
    mem[8'h20] = 32'h1111_2222;
    bus.M_grant = 1'b0;
    clear_log();
    issue(8'h20, 8'h30, 5'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("dg_wait_req",  {31'b0, bus.M_req}, 32'd1);
      chk("dg_wait_addr", {24'b0, bus.M_address}, 32'h11);
    end
    bus.M_grant = 1'b1;
    tick();
    chk("dg_rd_addr", {24'b0, bus.M_address}, 32'h20);
    run_to_done("dg", 20);
    chk("dg_nwrites", log_addr.size(), 32'd1);
    chk_log("dg_w0", 0, 8'h30, 32'h1111_2222);

    // Grant lost during the first write: that write is dropped and word 0 replays
    mem[8'h40] = 32'hC0C0_C0C0;
    mem[8'h41] = 32'hC1C1_C1C1;
    clear_log();
    issue(8'h40, 8'h50, 5'd2);
    tick();
    tick();
    tick();
    chk("gl_wr0_wr", {31'b0, bus.M_wr}, 32'd1);
    bus.M_grant = 1'b0;
    tick();
    chk("gl_lost_wr",  {31'b0, bus.M_wr}, 32'd0);
    chk("gl_lost_req", {31'b0, bus.M_req}, 32'd1);
    tick();
    bus.M_grant = 1'b1;
    tick();
    chk("gl_reread_addr", {24'b0, bus.M_address}, 32'h40);
    run_to_done("gl", 30);
    chk("gl_nwrites", log_addr.size(), 32'd2);
    chk("gl_ndone",   done_cnt, 32'd1);
    chk_log("gl_w0", 0, 8'h50, 32'hC0C0_C0C0);
    chk_log("gl_w1", 1, 8'h51, 32'hC1C1_C1C1);

    // Address wrap on both source and destination
    mem[8'hFF] = 32'hF0F0_0000;
    mem[8'h00] = 32'hF1F1_0000;
    mem[8'h01] = 32'hF2F2_0000;
    clear_log();
    issue(8'hFF, 8'hFE, 5'd3);
    run_to_done("wrap", 40);
    chk("wrap_nwrites", log_addr.size(), 32'd3);
    chk_log("wrap_w0", 0, 8'hFE, 32'hF0F0_0000);
    chk_log("wrap_w1", 1, 8'hFF, 32'hF1F1_0000);
    chk_log("wrap_w2", 2, 8'h00, 32'hF2F2_0000);

    // Zero length: done right after start, never requests the bus
    clear_log();
    issue(8'h33, 8'h44, 5'd0);
    chk("len0_done", {31'b0, done}, 32'd1);
    chk("len0_busy", {31'b0, busy}, 32'd1);
    tick();
    chk("len0_done_off", {31'b0, done}, 32'd0);
    chk("len0_nreq",     req_cnt, 32'd0);

    // Oversized length clamps to 16 words
    for (int k = 0; k < 18; k++) mem[8'h80 + k] = 32'hD000_0000 + k;
    clear_log();
    issue(8'h80, 8'hA0, 5'd20);
    run_to_done("len20", 100);
    chk("len20_nwrites", log_addr.size(), 32'd16);
    chk_log("len20_first", 0, 8'hA0, 32'hD000_0000);
    chk_log("len20_last", 15, 8'hAF, 32'hD000_000F);

    // Reset during the read of word 1
    mem[8'h01] = 32'h0000_000A;
    mem[8'h02] = 32'h0000_000B;
    clear_log();
    issue(8'h01, 8'h10, 5'd3);
    for (int k = 0; k < 5; k++) tick();
    chk("mr_rdd1_addr", {24'b0, bus.M_address}, 32'h02);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_req",  {31'b0, bus.M_req}, 32'd0);
    chk("mr_wr",   {31'b0, bus.M_wr}, 32'd0);
    chk("mr_addr", {24'b0, bus.M_address}, 32'h00);
    chk("mr_dout", bus.M_dout, 32'h0);
    chk("mr_busy", {31'b0, busy}, 32'd0);
    chk("mr_done", {31'b0, done}, 32'd0);
    for (int k = 0; k < 5; k++) tick();
    chk("mr_ndone",   done_cnt, 32'd0);
    chk("mr_nwrites", log_addr.size(), 32'd1);
    clear_log();
    issue(8'h01, 8'h60, 5'd1);
    run_to_done("mr_restart", 20);
    chk("mr_restart_nwrites", log_addr.size(), 32'd1);
    chk_log("mr_restart_w0", 0, 8'h60, 32'h0000_000A);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_dma_master.md
BUS_DMA_MASTER -- requirements
Module: bus_dma_master

Interface
REQ-001 The block SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port start, input, 1 bit: command strobe, sampled only in IDLE.
REQ-005 Port src_addr, input, 8 bits: first source word address, latched on an accepted start.
REQ-006 Port dst_addr, input, 8 bits: first destination word address, latched on an accepted start.
REQ-007 Port length, input, 5 bits: number of words to copy (0..16); values 17..31 SHALL be treated as 16.
REQ-008 Port M_grant, input, 1 bit: bus grant from the arbiter.
REQ-009 Port M_din, input, 32 bits: read data returned by the bus.
REQ-010 Port M_req, output, 1 bit: bus request.
REQ-011 Port M_wr, output, 1 bit: 1 = write, 0 = read.
REQ-012 Port M_address, output, 8 bits: bus address.
REQ-013 Port M_dout, output, 32 bits: write data.
REQ-014 Port busy, output, 1 bit: high in every state except IDLE.
REQ-015 Port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-016 The state machine SHALL have the states IDLE, REQ, RD_ADDR, RD_DATA, WR and DONE, and all outputs SHALL be registered.
REQ-017 IDLE: on start=1 with effective length>0, the block SHALL latch src/dst/length, clear the word index i to 0, and go to REQ.
REQ-018 IDLE: on start=1 with length=0, the block SHALL go directly to DONE and SHALL NOT assert M_req.
REQ-019 IDLE: start=0 SHALL hold IDLE.
REQ-020 M_req SHALL be 1 in the states REQ, RD_ADDR, RD_DATA and WR, and 0 in IDLE and DONE.
REQ-021 REQ: the block SHALL wait while M_grant=0 and go to RD_ADDR in the cycle after M_grant=1 is sampled.
REQ-022 RD_ADDR: M_address SHALL be (src+i) mod 256 and M_wr SHALL be 0; the next state SHALL be RD_DATA.
REQ-023 RD_DATA: the block SHALL capture M_din into an internal 32-bit word buffer, hold M_address and M_wr=0, and go to WR (read latency is one cycle after the address is presented).
REQ-024 WR: M_address SHALL be (dst+i) mod 256, M_wr SHALL be 1, and M_dout SHALL equal the buffer.
REQ-025 WR exit: the block SHALL increment i, then go to DONE if i+1 = length, else to RD_ADDR.
REQ-026 M_wr SHALL be high for exactly one cycle per word, so each word takes 3 cycles while granted.
REQ-027 Grant loss: if M_grant=0 is sampled in RD_ADDR, RD_DATA or WR, the block SHALL go to REQ with M_wr=0, and i SHALL NOT advance.
REQ-028 After a grant loss, the interrupted word SHALL restart from RD_ADDR once the grant returns, and that WR cycle SHALL be discarded.
REQ-029 DONE: done SHALL be 1 for exactly one cycle and busy SHALL be 1; the next state SHALL be IDLE.
REQ-030 start SHALL be ignored in every state except IDLE.
REQ-031 When not in RD_ADDR, RD_DATA or WR, M_address and M_dout SHALL hold their last value, and M_wr SHALL be 0.
REQ-032 Source and destination address arithmetic SHALL be 8-bit, wrapping 0xFF->0x00, so the copy continues from the wrapped address.
REQ-033 Overlapping source and destination ranges SHALL be copied strictly word by word in ascending order, with no detection of the overlap.

Reset
REQ-034 While reset=1 at a clock edge, the block SHALL enter IDLE with M_req=0, M_wr=0, M_address=8'h00, M_dout=32'h0, busy=0, done=0, i=0 and buffer=0.
REQ-035 Reset asserted mid-transfer SHALL abort the transfer immediately, with no completion of the current write and no done pulse.
REQ-036 Reset SHALL take priority over start and M_grant.

Verification
REQ-037 The bench SHALL cover a granted copy: start, src=0x01, dst=0x10, length=2, M_grant tied 1, bus returns 0xA then 0xB -> writes 0xA@0x10 and 0xB@0x11, one M_wr pulse each, done one cycle after the second write, busy low the cycle after.
REQ-038 The bench SHALL cover delayed grant: M_grant held 0 for 4 cycles after start -> M_req=1 throughout, no M_address activity, and the transfer begins the cycle after the grant rises.
REQ-039 The bench SHALL cover grant loss: M_grant dropped during WR of word 0 for 2 cycles -> no write is counted, word 0 is re-read from src, and exactly length completed writes plus one done pulse result.
REQ-040 The bench SHALL cover wrap: src=0xFF, dst=0xFE, length=3 -> reads from 0xFF, 0x00, 0x01 and writes to 0xFE, 0xFF, 0x00.
REQ-041 The bench SHALL cover length=0 and length=20: 0 -> done pulses 1 cycle after start with M_req never high; 20 -> exactly 16 words are copied.
REQ-042 The bench SHALL cover reset mid-transfer: reset=1 during RD_DATA of word 1 -> the next cycle shows all outputs at reset values, no done pulse, and start is accepted normally afterwards.
